// File: rtl/spi_slot_cmd_decoder.sv
// SPI slave command decoder: shifts in MSB-first frames, decodes opcode+payload into
// registered fields and one-cycle strobes, and returns a status word on sdo.
module spi_slot_cmd_decoder #(
   parameter int NUM_REELS = 3,
   parameter int IDX_W     = 4,
   parameter int CREDIT_W  = 12,
   parameter int OP_W      = 4,
   parameter int FRAME_W   = 16
) (
   input  logic                       sclk,
   input  logic                       reset_n,
   input  logic                       cs,
   input  logic                       copi,
   input  logic                       spin_busy,
   output logic                       sdo,
   output logic [NUM_REELS*IDX_W-1:0] reel_idx,
   output logic                       start_spin,
   output logic [CREDIT_W-1:0]        win_credits,
   output logic                       is_win,
   output logic [CREDIT_W-1:0]        total_credits,
   output logic                       is_total,
   output logic                       err
);

   localparam int CNT_W  = $clog2(FRAME_W);
   localparam int REEL_W = NUM_REELS * IDX_W;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   bit_cnt;
   logic [FRAME_W-2:0] rx;
   logic [FRAME_W-1:0] tx;
   logic [FRAME_W-1:0] frame;
   logic [FRAME_W-1:0] status;
   logic [OP_W-1:0]    op;
   logic [OP_W-1:0]    last_op;
   logic [7:0]         frame_cnt;
   logic               last_bit;
   logic               op_spin, op_win, op_upd, op_clr;
   logic               accept;

   // The incoming bit is folded in combinationally so decode happens on the capturing edge.
   assign frame    = {rx, copi};
   assign op       = frame[FRAME_W-1 -: OP_W];
   assign last_bit = (state == SHIFT) && !cs && (bit_cnt == CNT_W'(FRAME_W - 1));
   assign sdo      = tx[FRAME_W-1] & ~cs;

   always_comb begin
      op_spin = (op == OP_W'(1));
      op_win  = (op == OP_W'(2));
      op_upd  = (op == OP_W'(3));
      op_clr  = (op == OP_W'(4));
      accept  = last_bit && ((op_spin && !spin_busy) || op_win || op_upd || op_clr);
      status  = '0;
      status[FRAME_W-1 -: OP_W] = last_op;
      status[FRAME_W-OP_W-1]    = err;
      status[FRAME_W-OP_W-2]    = spin_busy;
      status[7:0]               = frame_cnt;
   end

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cs) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt       <= '0;
         rx            <= '0;
         tx            <= '0;
         last_op       <= '0;
         frame_cnt     <= '0;
         reel_idx      <= '0;
         start_spin    <= 1'b0;
         win_credits   <= '0;
         is_win        <= 1'b0;
         total_credits <= '0;
         is_total      <= 1'b0;
         err           <= 1'b0;
      end else begin
         start_spin <= 1'b0;
         is_win     <= 1'b0;
         is_total   <= 1'b0;
         if (cs) begin
            // A deselect while still shifting (including on the final bit) aborts the frame.
            bit_cnt <= '0;
            tx      <= status;
            if (state == SHIFT) err <= 1'b1;
         end else if (state != DONE) begin
            rx      <= frame[FRAME_W-2:0];
            tx      <= {tx[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
               if (op_spin) begin
                  if (spin_busy) begin
                     err <= 1'b1;
                  end else begin
                     reel_idx   <= frame[REEL_W-1:0];
                     start_spin <= 1'b1;
                  end
               end else if (op_win) begin
                  win_credits <= frame[CREDIT_W-1:0];
                  is_win      <= 1'b1;
               end else if (op_upd) begin
                  total_credits <= frame[CREDIT_W-1:0];
                  is_total      <= 1'b1;
               end else if (op_clr) begin
                  err <= 1'b0;
               end else begin
                  err <= 1'b1;
               end
               if (accept) begin
                  last_op   <= op;
                  frame_cnt <= frame_cnt + 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_slot_cmd_decoder.sv
// Directed bench for spi_slot_cmd_decoder: frames, strobes, error paths, status readback, wrap, reset.
module tb_spi_slot_cmd_decoder;

   logic        sclk = 1'b0;
   logic        reset_n;
   logic        cs;
   logic        copi;
   logic        spin_busy;
   logic        sdo;
   logic [11:0] reel_idx;
   logic        start_spin;
   logic [11:0] win_credits;
   logic        is_win;
   logic [11:0] total_credits;
   logic        is_total;
   logic        err;

   int checks   = 0;
   int failures = 0;

   spi_slot_cmd_decoder dut (
      .sclk          (sclk),
      .reset_n       (reset_n),
      .cs            (cs),
      .copi          (copi),
      .spin_busy     (spin_busy),
      .sdo           (sdo),
      .reel_idx      (reel_idx),
      .start_spin    (start_spin),
      .win_credits   (win_credits),
      .is_win        (is_win),
      .total_credits (total_credits),
      .is_total      (is_total),
      .err           (err)
   );

   always #5 sclk = ~sclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives nbits of w (MSB first); a full frame gets one trailing clock before deselect.
   // Returns the bits seen on sdo and how many cycles each strobe was high.
   task automatic do_frame(input logic [15:0] w, input int nbits, input logic busy,
                           output logic [15:0] rd, output int n_spin, output int n_win,
                           output int n_tot);
      rd = '0; n_spin = 0; n_win = 0; n_tot = 0;
      @(negedge sclk);
      spin_busy = busy;
      cs = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         if (i > 0) @(negedge sclk);
         copi = w[15-i];
         #1;
         rd[15-i] = sdo;
         n_spin += int'(start_spin); n_win += int'(is_win); n_tot += int'(is_total);
      end
      if (nbits == 16) begin
         @(negedge sclk);
         n_spin += int'(start_spin); n_win += int'(is_win); n_tot += int'(is_total);
      end
      @(negedge sclk);
      n_spin += int'(start_spin); n_win += int'(is_win); n_tot += int'(is_total);
      spin_busy = 1'b0;
      cs = 1'b1;
      copi = 1'b0;
      repeat (2) begin
         @(negedge sclk);
         n_spin += int'(start_spin); n_win += int'(is_win); n_tot += int'(is_total);
      end
   endtask

   initial begin
      logic [15:0] rd;
      int ns, nw, nt, sum_w;

      reset_n = 1'b0; cs = 1'b1; copi = 1'b0; spin_busy = 1'b0;
      #12;
      check("reset_outputs", {reel_idx, win_credits, total_credits, start_spin, is_win, is_total}, '0);
      check("reset_err_sdo", {err, sdo}, 2'b00);
      @(negedge sclk); reset_n = 1'b1;
      repeat (3) @(negedge sclk);
      check("idle_sdo", {sdo, err}, 2'b00);

      do_frame(16'h1A5C, 16, 1'b0, rd, ns, nw, nt);
      check("spin_reel_idx", reel_idx, 12'hA5C);
      check("spin_pulse", ns, 1);
      check("spin_other_strobes", nw + nt, 0);
      check("spin_resp", rd, 16'h0000);

      do_frame(16'h2123, 16, 1'b0, rd, ns, nw, nt);
      check("win_credits", win_credits, 12'h123);
      check("win_pulse", nw, 1);
      check("win_resp", rd, 16'h1001);

      do_frame(16'h3FFF, 16, 1'b0, rd, ns, nw, nt);
      check("total_credits", total_credits, 12'hFFF);
      check("total_pulse", nt, 1);
      check("update_reel_hold", reel_idx, 12'hA5C);
      check("update_resp", rd, 16'h2002);

      do_frame(16'h1777, 16, 1'b1, rd, ns, nw, nt);
      check("busy_no_pulse", ns, 0);
      check("busy_reel_hold", reel_idx, 12'hA5C);
      check("busy_err", err, 1'b1);
      check("busy_resp", rd, 16'h3003);

      do_frame(16'h0000, 9, 1'b0, rd, ns, nw, nt);
      check("short1_resp", rd[15:7], 9'((16'h3803) >> 7));
      check("short1_strobes", ns + nw + nt, 0);

      do_frame(16'h4000, 16, 1'b0, rd, ns, nw, nt);
      check("clr1_err", err, 1'b0);
      check("clr1_resp", rd, 16'h3803);

      do_frame(16'h1FFF, 9, 1'b0, rd, ns, nw, nt);
      check("short2_err", err, 1'b1);
      check("short2_no_spin", {ns, 20'(reel_idx)}, {32'd0, 20'hA5C});
      check("short2_resp", rd[15:7], 9'((16'h4004) >> 7));

      do_frame(16'h4000, 16, 1'b0, rd, ns, nw, nt);
      check("clr2_err", err, 1'b0);
      check("clr2_resp", rd, 16'h4804);

      do_frame(16'h9000, 16, 1'b0, rd, ns, nw, nt);
      check("badop_err", err, 1'b1);
      check("badop_strobes", ns + nw + nt, 0);
      check("badop_fields", {reel_idx, win_credits, total_credits}, {12'hA5C, 12'h123, 12'hFFF});
      check("badop_resp", rd, 16'h4005);

      do_frame(16'h4000, 16, 1'b0, rd, ns, nw, nt);
      check("clr3_err", err, 1'b0);
      check("clr3_resp", rd, 16'h4805);

      // 6 accepted so far; 250 more wraps the 8-bit frame counter to 0.
      sum_w = 0;
      for (int i = 0; i < 250; i++) begin
         do_frame(16'h2000 | 16'(i), 16, 1'b0, rd, ns, nw, nt);
         sum_w += nw;
      end
      check("wrap_win_pulses", sum_w, 250);
      check("wrap_win_last", win_credits, 12'h0F9);
      do_frame(16'h3ABC, 16, 1'b0, rd, ns, nw, nt);
      check("wrap_resp", rd, 16'h2000);
      check("wrap_total", total_credits, 12'hABC);

      @(negedge sclk);
      cs = 1'b0;
      for (int i = 0; i < 5; i++) begin
         copi = i[0];
         @(negedge sclk);
      end
      #2 reset_n = 1'b0;
      #1;
      check("midreset_fields", {reel_idx, win_credits, total_credits}, '0);
      check("midreset_flags", {start_spin, is_win, is_total, err}, 4'b0000);
      cs = 1'b1;
      @(negedge sclk); reset_n = 1'b1;
      repeat (2) @(negedge sclk);
      check("midreset_sdo", sdo, 1'b0);

      do_frame(16'h1123, 16, 1'b0, rd, ns, nw, nt);
      check("post_reset_reel", reel_idx, 12'h123);
      check("post_reset_pulse", ns, 1);
      check("post_reset_resp", rd, 16'h0000);
      do_frame(16'h2456, 16, 1'b0, rd, ns, nw, nt);
      check("post_reset_resp2", rd, 16'h1001);
      check("post_reset_win", win_credits, 12'h456);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
